registers_bank_mp: RTL and testbench

REGISTERS_BANK_MP -- requirements
Module: registers_bank_mp

---
 rtl/registers_bank_mp_if.sv | 45 ++++
 rtl/registers_bank_mp.sv | 149 ++++++++++++++
 tb/tb_registers_bank_mp.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/registers_bank_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : registers_bank_mp_if
// Description : Bus bundle for registers_bank_mp: write port, packed
//               multi-port read addresses/data, and the dump stream
//               handshake. The slave modport is the register bank side.
// Revision    : 1.0 - initial release
// ============================================================================
interface registers_bank_mp_if #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 5,
  parameter int N_READ  = 2
);

  // Write port (from write-back)
  logic                        i_reg_write;
  logic [NB_ADDR-1:0]          i_write_reg;
  logic [NB_DATA-1:0]          i_write_data;

  // Read ports, port k at slice k
  logic [N_READ*NB_ADDR-1:0]   i_read_regs;
  logic [N_READ*NB_DATA-1:0]   o_read_data;

  // Dump stream
  logic                        i_dump_start;
  logic                        i_dump_ready;
  logic                        o_dump_valid;
  logic [NB_ADDR-1:0]          o_dump_addr;
  logic [NB_DATA-1:0]          o_dump_data;
  logic                        o_dump_done;

  modport master (
    output i_reg_write, i_write_reg, i_write_data, i_read_regs,
           i_dump_start, i_dump_ready,
    input  o_read_data, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

  modport slave (
    input  i_reg_write, i_write_reg, i_write_data, i_read_regs,
           i_dump_start, i_dump_ready,
    output o_read_data, o_dump_valid, o_dump_addr, o_dump_data, o_dump_done
  );

endinterface
`default_nettype wire

// File: rtl/registers_bank_mp.sv
`default_nettype none
// ============================================================================
// Module      : registers_bank_mp
// Description : Multi-read-port register bank with one write port, registered
//               read ports, optional hardwired-zero register 0 and a
//               valid/ready dump stream that walks every register once.
//               Optional macro REGBANK_BYPASS_EN: a read of the register being
//               written in the same cycle returns the new data (write-first);
//               without it the old stored value is returned (read-first).
// Revision    : 1.0 - initial release
// ============================================================================
module registers_bank_mp #(
  parameter int NB_DATA    = 32,
  parameter int NB_ADDR    = 5,
  parameter int BANK_DEPTH = 32,
  parameter int N_READ     = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                i_clock,
  input  logic                i_reset_n,
  registers_bank_mp_if.slave  bus
);

  // Storage is sized to the full address space; rows at or beyond BANK_DEPTH
  // are never written and stay at their reset value of zero.
  localparam int                 c_rows  = 2**NB_ADDR;
  localparam logic [NB_ADDR:0]   c_depth = (NB_ADDR+1)'(BANK_DEPTH);
  localparam logic [NB_ADDR:0]   c_last  = (NB_ADDR+1)'(BANK_DEPTH-1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } dump_state_t;

  logic [NB_DATA-1:0]               regs_q [c_rows];

  logic                             w_wr_in_range;
  logic                             w_wr_is_zero;
  logic                             w_wr_en;

  logic [N_READ-1:0][NB_ADDR-1:0]   w_raddr;
  logic [N_READ-1:0][NB_DATA-1:0]   rdata_d;
  logic [N_READ-1:0][NB_DATA-1:0]   rdata_q;

  dump_state_t                      state_q;
  dump_state_t                      state_d;
  logic [NB_ADDR-1:0]               cnt_q;
  logic [NB_ADDR-1:0]               cnt_d;

  // Qualify the write: in-range address and not the hardwired zero register
  always_comb begin
    w_wr_in_range = ({1'b0, bus.i_write_reg} < c_depth);
    w_wr_is_zero  = (ZERO_REG != 0) && (bus.i_write_reg == '0);
    w_wr_en       = bus.i_reg_write && w_wr_in_range && !w_wr_is_zero;
  end

  // Register array update; cleared asynchronously on reset
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < c_rows; i++) begin
        regs_q[i] <= '0;
      end
    end else if (w_wr_en) begin
      regs_q[bus.i_write_reg] <= bus.i_write_data;
    end
  end

  // The packed 2-D view lines element k up with slice [k*NB_ADDR +: NB_ADDR]
  assign w_raddr = bus.i_read_regs;

  // Per-port read selection, with optional same-cycle write forwarding
  always_comb begin
    for (int k = 0; k < N_READ; k++) begin
      rdata_d[k] = '0;
      if ({1'b0, w_raddr[k]} < c_depth) begin
        rdata_d[k] = regs_q[w_raddr[k]];
`ifdef REGBANK_BYPASS_EN
        if (w_wr_en && (w_raddr[k] == bus.i_write_reg)) begin
          rdata_d[k] = bus.i_write_data;
        end
`endif
      end
    end
  end

  // Registered read outputs, one cycle after the address is presented
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.o_read_data = rdata_q;

  // Dump FSM state and beat counter
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Dump FSM next state and handshake outputs
  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    bus.o_dump_valid = 1'b0;
    bus.o_dump_done  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.i_dump_start) begin
          state_d = ST_DUMP;
          cnt_d   = '0;
        end
      end
      ST_DUMP: begin
        bus.o_dump_valid = 1'b1;
        if (bus.i_dump_ready) begin
          if ({1'b0, cnt_q} == c_last) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        bus.o_dump_done = 1'b1;
        state_d         = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Beat contents come straight from the array, so a same-cycle write is not seen
  assign bus.o_dump_addr = cnt_q;
  assign bus.o_dump_data = regs_q[cnt_q];

endmodule
`default_nettype wire

// File: tb/tb_registers_bank_mp.sv
`default_nettype none
// ============================================================================
// Module      : tb_registers_bank_mp
// Description : Self-checking bench for registers_bank_mp: directed and
//               random read/write traffic against an array model, plus dump
//               streams with back-pressure, ignored restart and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_registers_bank_mp;

  localparam int NB_DATA    = 32;
  localparam int NB_ADDR    = 5;
  localparam int BANK_DEPTH = 32;
  localparam int N_READ     = 2;
  localparam int ZERO_REG   = 1;

  logic clk;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  logic [NB_DATA-1:0] model [BANK_DEPTH];

  registers_bank_mp_if #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR),
    .N_READ  (N_READ)
  ) bus ();

  registers_bank_mp #(
    .NB_DATA    (NB_DATA),
    .NB_ADDR    (NB_ADDR),
    .BANK_DEPTH (BANK_DEPTH),
    .N_READ     (N_READ),
    .ZERO_REG   (ZERO_REG)
  ) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .bus       (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NB_DATA-1:0] rd_port(input int k);
    return bus.o_read_data[k*NB_DATA +: NB_DATA];
  endfunction

  // Value a read of address ra should capture at the coming edge
  function automatic logic [NB_DATA-1:0] exp_read(input int ra, input bit we, input int wa,
                                                   input logic [NB_DATA-1:0] wd);
    if (ra >= BANK_DEPTH) return '0;
`ifdef REGBANK_BYPASS_EN
    if (we && ra == wa && !(ZERO_REG != 0 && wa == 0)) return wd;
`else
    if (we && wd == '1 && ra < 0) return wd;
`endif
    return model[ra];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < BANK_DEPTH; i++) model[i] = '0;
  endtask

  // One bus cycle: drive write + two reads, clock, check registered reads
  task automatic cycle(input bit we, input int wa, input logic [NB_DATA-1:0] wd,
                       input int ra0, input int ra1);
    logic [NB_DATA-1:0] e0, e1;
    bus.i_reg_write  = we;
    bus.i_write_reg  = NB_ADDR'(wa);
    bus.i_write_data = wd;
    bus.i_read_regs  = {NB_ADDR'(ra1), NB_ADDR'(ra0)};
    e0 = exp_read(ra0, we, wa, wd);
    e1 = exp_read(ra1, we, wa, wd);
    if (we && wa < BANK_DEPTH && !(ZERO_REG != 0 && wa == 0)) model[wa] = wd;
    @(posedge clk); #1;
    bus.i_reg_write = 1'b0;
    chk_eq("read_p0", rd_port(0), e0);
    chk_eq("read_p1", rd_port(1), e1);
  endtask

  task automatic rand_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      int wa, ra0, ra1;
      wa  = int'($urandom_range(BANK_DEPTH-1, 0));
      ra0 = ($urandom_range(3, 0) == 0) ? wa : int'($urandom_range(BANK_DEPTH-1, 0));
      ra1 = ($urandom_range(3, 0) == 0) ? ra0 : int'($urandom_range(BANK_DEPTH-1, 0));
      cycle(bit'($urandom_range(1, 0)), wa, $urandom, ra0, ra1);
    end
  endtask

  // Stream a full dump; optional stall beat, restart-attempt beat and abort beat
  task automatic run_dump(input int stall_beat, input int restart_beat, input int abort_beat);
    int idx   = 0;
    int stall = 0;
    int guard = 0;
    bus.i_dump_start = 1'b1;
    bus.i_dump_ready = 1'b1;
    @(posedge clk); #1;
    bus.i_dump_start = 1'b0;
    while (idx < BANK_DEPTH && guard < 200) begin
      guard++;
      chk_eq("dump_valid", bus.o_dump_valid, 1);
      chk_eq("dump_addr", bus.o_dump_addr, idx);
      chk_eq("dump_data", bus.o_dump_data, model[idx]);
      chk_eq("dump_done_low", bus.o_dump_done, 0);
      if (idx == abort_beat) begin
        rst_n = 1'b0;
        #1;
        chk_eq("abort_valid", bus.o_dump_valid, 0);
        chk_eq("abort_done", bus.o_dump_done, 0);
        chk_eq("abort_rd0", rd_port(0), 0);
        model_clear();
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          chk_eq("abort_no_done", bus.o_dump_done, 0);
          chk_eq("abort_no_valid", bus.o_dump_valid, 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_eq("post_abort_done", bus.o_dump_done, 0);
        chk_eq("post_abort_valid", bus.o_dump_valid, 0);
        return;
      end
      bus.i_dump_start = (idx == restart_beat);
      if (idx == stall_beat && stall < 3) begin
        bus.i_dump_ready = 1'b0;
        stall++;
      end else begin
        bus.i_dump_ready = 1'b1;
        idx++;
      end
      @(posedge clk); #1;
    end
    bus.i_dump_start = 1'b0;
    chk_eq("dump_timeout", guard < 200, 1);
    chk_eq("dump_done", bus.o_dump_done, 1);
    chk_eq("done_valid_low", bus.o_dump_valid, 0);
    @(posedge clk); #1;
    chk_eq("done_one_cycle", bus.o_dump_done, 0);
    chk_eq("idle_valid_low", bus.o_dump_valid, 0);
  endtask

  initial begin
    bus.i_reg_write  = 1'b0;
    bus.i_write_reg  = '0;
    bus.i_write_data = '0;
    bus.i_read_regs  = '0;
    bus.i_dump_start = 1'b0;
    bus.i_dump_ready = 1'b0;
    model_clear();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_valid", bus.o_dump_valid, 0);
    chk_eq("rst_done", bus.o_dump_done, 0);
    chk_eq("rst_rd0", rd_port(0), 0);
    chk_eq("rst_rd1", rd_port(1), 0);
    chk_eq("rst_addr", bus.o_dump_addr, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fresh bank reads zero
    cycle(1'b0, 0, '0, 5, 31);
    chk_eq("r5_zero", rd_port(0), 32'h0);
    chk_eq("r31_zero", rd_port(1), 32'h0);

    // Same-cycle write/read of r7, then the following read
    cycle(1'b1, 7, 32'hDEADBEEF, 7, 3);
`ifdef REGBANK_BYPASS_EN
    chk_eq("r7_same_cycle", rd_port(0), 32'hDEADBEEF);
`else
    chk_eq("r7_same_cycle", rd_port(0), 32'h0);
`endif
    cycle(1'b0, 0, '0, 7, 7);
    chk_eq("r7_next_p0", rd_port(0), 32'hDEADBEEF);
    chk_eq("r7_next_p1", rd_port(1), 32'hDEADBEEF);

    // Hardwired zero register
    cycle(1'b1, 0, 32'h12345678, 0, 0);
    cycle(1'b0, 0, '0, 0, 0);
    chk_eq("r0_p0", rd_port(0), 32'h0);
    chk_eq("r0_p1", rd_port(1), 32'h0);

    rand_cycles(300);

    // Preload rN = N + 0x100 and stream it out
    for (int n = 0; n < BANK_DEPTH; n++) begin
      cycle(1'b1, n, NB_DATA'(n + 32'h100), n, BANK_DEPTH-1-n);
    end
    chk_eq("preload_r31", model[31], 32'h11F);
    run_dump(-1, -1, -1);

    // Back-pressure at beat 10 and an ignored restart at beat 15
    run_dump(10, 15, -1);

    // Reset in the middle of a dump, then a clean dump of the cleared bank
    run_dump(-1, -1, 20);
    run_dump(-1, -1, -1);

    rand_cycles(200);
    run_dump(int'($urandom_range(BANK_DEPTH-2, 1)), 3, -1);
    rand_cycles(20);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
